// File: rtl/btb_pkg.sv
// Shared types, constants and helpers for the 2-way branch target buffer.
package btb_pkg;

  localparam int unsigned BTB_WIDTH   = 32;
  localparam int unsigned BTB_SETS    = 64;
  localparam int unsigned BTB_INDEX_W = $clog2(BTB_SETS);
  localparam int unsigned BTB_TAG_W   = BTB_WIDTH - BTB_INDEX_W - 2;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  typedef struct packed {
    logic                 valid;
    logic [BTB_TAG_W-1:0] tag;
    logic [BTB_WIDTH-1:0] target;
    logic [1:0]           ctr;
  } btb_entry_t;

  typedef enum logic {
    BTB_IDLE,
    BTB_SWEEP
  } btb_state_e;

  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    return (c == CTR_ST) ? CTR_ST : c + 2'd1;
  endfunction

  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    return (c == CTR_SNT) ? CTR_SNT : c - 2'd1;
  endfunction

endpackage

// File: rtl/btb_way.sv
// One BTB way: lookup and update-probe read ports, one write port, per-set valid clear.
module btb_way
  import btb_pkg::*;
#(
  parameter int unsigned SETS    = BTB_SETS,
  parameter int unsigned INDEX_W = $clog2(SETS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [INDEX_W-1:0]   lk_index,
  input  logic [BTB_TAG_W-1:0] lk_tag,
  output logic                 lk_hit,
  output logic                 lk_taken,
  output logic [BTB_WIDTH-1:0] lk_target,
  input  logic [INDEX_W-1:0]   up_index,
  input  logic [BTB_TAG_W-1:0] up_tag,
  output logic                 up_hit,
  output logic                 up_valid,
  output logic [1:0]           up_ctr,
  input  logic                 wr_en,
  input  logic [INDEX_W-1:0]   wr_index,
  input  btb_entry_t           wr_entry,
  input  logic                 clr_en,
  input  logic [INDEX_W-1:0]   clr_index
);

  logic [SETS-1:0]      valid_q;
  logic [BTB_TAG_W-1:0] tag_q    [SETS];
  logic [BTB_WIDTH-1:0] target_q [SETS];
  logic [1:0]           ctr_q    [SETS];

  // Valid bits are the only reset state; a write and a clear never target the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else begin
      if (clr_en) valid_q[clr_index] <= 1'b0;
      if (wr_en)  valid_q[wr_index]  <= wr_entry.valid;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_index]    <= wr_entry.tag;
      target_q[wr_index] <= wr_entry.target;
      ctr_q[wr_index]    <= wr_entry.ctr;
    end
  end

  always_comb begin
    lk_hit    = valid_q[lk_index] && (tag_q[lk_index] == lk_tag);
    lk_taken  = ctr_q[lk_index][1];
    lk_target = target_q[lk_index];
    up_valid  = valid_q[up_index];
    up_hit    = valid_q[up_index] && (tag_q[up_index] == up_tag);
    up_ctr    = ctr_q[up_index];
  end

endmodule

// File: rtl/btb_2way.sv
// 2-way set-associative BTB with same-cycle lookup and write-first update bypass.
// Optional invalidate sweep (flush_req/busy) is built when BTB_INVALIDATE_EN is defined.
module btb_2way
  import btb_pkg::*;
#(
  parameter int unsigned WIDTH = BTB_WIDTH,
  parameter int unsigned SETS  = BTB_SETS,
  parameter int unsigned TAG_W = WIDTH - $clog2(SETS) - 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] PC_F,
  output logic             hit_F,
  output logic             taken_F,
  output logic [WIDTH-1:0] target_F,
  input  logic             upd_en_EX,
  input  logic [WIDTH-1:0] PC_EX,
  input  logic [WIDTH-1:0] target_EX,
  input  logic             taken_EX,
`ifdef BTB_INVALIDATE_EN
  input  logic             flush_req,
`endif
  output logic             busy
);

  localparam int unsigned INDEX_W = $clog2(SETS);

  logic [INDEX_W-1:0] f_index, ex_index, clr_index;
  logic [TAG_W-1:0]   f_tag, ex_tag;
  logic               sweeping, clr_en, upd_act, bypass;
  logic               lk_hit0, lk_hit1, lk_tk0, lk_tk1;
  logic [WIDTH-1:0]   lk_tg0, lk_tg1;
  logic               up_hit0, up_hit1, up_v0, up_v1;
  logic [1:0]         up_ctr0, up_ctr1;
  logic               wr_en0, wr_en1, lru_we, lru_d, victim;
  btb_entry_t         wr_entry;
  logic [SETS-1:0]    lru_q;

  assign f_index  = PC_F[INDEX_W+1:2];
  assign f_tag    = PC_F[WIDTH-1:INDEX_W+2];
  assign ex_index = PC_EX[INDEX_W+1:2];
  assign ex_tag   = PC_EX[WIDTH-1:INDEX_W+2];

  // Updates are dropped while held in reset or while the sweep owns the arrays.
  assign upd_act = upd_en_EX && rst && !sweeping;
  assign bypass  = upd_act && (PC_EX == PC_F);

  btb_way #(.SETS(SETS), .INDEX_W(INDEX_W)) u_way0 (
    .clk, .rst,
    .lk_index(f_index), .lk_tag(f_tag), .lk_hit(lk_hit0), .lk_taken(lk_tk0), .lk_target(lk_tg0),
    .up_index(ex_index), .up_tag(ex_tag), .up_hit(up_hit0), .up_valid(up_v0), .up_ctr(up_ctr0),
    .wr_en(wr_en0), .wr_index(ex_index), .wr_entry(wr_entry),
    .clr_en(clr_en), .clr_index(clr_index)
  );

  btb_way #(.SETS(SETS), .INDEX_W(INDEX_W)) u_way1 (
    .clk, .rst,
    .lk_index(f_index), .lk_tag(f_tag), .lk_hit(lk_hit1), .lk_taken(lk_tk1), .lk_target(lk_tg1),
    .up_index(ex_index), .up_tag(ex_tag), .up_hit(up_hit1), .up_valid(up_v1), .up_ctr(up_ctr1),
    .wr_en(wr_en1), .wr_index(ex_index), .wr_entry(wr_entry),
    .clr_en(clr_en), .clr_index(clr_index)
  );

  // Training: hit retrains in place, taken miss allocates (invalid way first, then LRU).
  always_comb begin
    wr_en0          = 1'b0;
    wr_en1          = 1'b0;
    lru_we          = 1'b0;
    lru_d           = 1'b0;
    victim          = 1'b0;
    wr_entry.valid  = 1'b1;
    wr_entry.tag    = ex_tag;
    wr_entry.target = target_EX;
    wr_entry.ctr    = CTR_WT;
    if (upd_act) begin
      if (up_hit0 || up_hit1) begin
        wr_entry.ctr = taken_EX ? ctr_inc(up_hit0 ? up_ctr0 : up_ctr1)
                                : ctr_dec(up_hit0 ? up_ctr0 : up_ctr1);
        wr_en0 = up_hit0;
        wr_en1 = up_hit1;
        lru_we = 1'b1;
        lru_d  = up_hit0;
      end else if (taken_EX) begin
        victim = !up_v0 ? 1'b0 : (!up_v1 ? 1'b1 : lru_q[ex_index]);
        wr_en0 = !victim;
        wr_en1 = victim;
        lru_we = 1'b1;
        lru_d  = !victim;
      end
    end
  end

  // LRU bit names the way to replace next.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lru_q <= '0;
    end else if (lru_we) begin
      lru_q[ex_index] <= lru_d;
    end
  end

  always_comb begin
    hit_F    = 1'b0;
    taken_F  = 1'b0;
    target_F = '0;
    if (bypass) begin
      hit_F    = 1'b1;
      taken_F  = taken_EX;
      target_F = target_EX;
    end else if (!sweeping && lk_hit0) begin
      hit_F    = 1'b1;
      taken_F  = lk_tk0;
      target_F = lk_tg0;
    end else if (!sweeping && lk_hit1) begin
      hit_F    = 1'b1;
      taken_F  = lk_tk1;
      target_F = lk_tg1;
    end
  end

  ap_one_way_hit: assert property (@(posedge clk) disable iff (!rst)
    !(lk_hit0 && lk_hit1) && !(up_hit0 && up_hit1));

`ifdef BTB_INVALIDATE_EN
  btb_state_e         state_q, state_d;
  logic [INDEX_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= BTB_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Sweep clears one set (both ways) per cycle, SETS cycles total.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_en  = 1'b0;
    case (state_q)
      BTB_IDLE: begin
        if (flush_req) begin
          state_d = BTB_SWEEP;
          cnt_d   = '0;
        end
      end
      BTB_SWEEP: begin
        clr_en = 1'b1;
        cnt_d  = cnt_q + INDEX_W'(1);
        if (cnt_q == INDEX_W'(SETS - 1)) state_d = BTB_IDLE;
      end
      default: state_d = BTB_IDLE;
    endcase
  end

  assign sweeping  = (state_q == BTB_SWEEP);
  assign clr_index = cnt_q;
  assign busy      = sweeping;
`else
  assign sweeping  = 1'b0;
  assign clr_en    = 1'b0;
  assign clr_index = '0;
  assign busy      = 1'b0;
`endif

endmodule

// File: tb/tb_btb_2way.sv
// Self-checking bench for btb_2way: directed scenarios plus random traffic against a
// keyed-map reference model (entries by word address, recency list for replacement).
module tb_btb_2way;

  localparam int SETS = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] PC_F = '0, PC_EX = '0, target_EX = '0;
  logic        upd_en_EX = 1'b0, taken_EX = 1'b0;
  logic        hit_F, taken_F, busy;
  logic [31:0] target_F;
  logic        flush_drv = 1'b0;
`ifdef BTB_INVALIDATE_EN
  logic        flush_req = 1'b0;
`endif

  btb_2way dut (
    .clk(clk), .rst(rst), .PC_F(PC_F), .hit_F(hit_F), .taken_F(taken_F), .target_F(target_F),
    .upd_en_EX(upd_en_EX), .PC_EX(PC_EX), .target_EX(target_EX), .taken_EX(taken_EX),
`ifdef BTB_INVALIDATE_EN
    .flush_req(flush_req),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] tgt; int ctr; } ment_t;
  ment_t       mdl [logic [29:0]];
  logic [29:0] order [$];
  int          sweep_left = 0;
  int          n_assert = 0, n_fail = 0;
  logic        obs_hit, obs_tk;
  logic [31:0] obs_tg;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int set_of(input logic [29:0] k);
    return int'(k) % SETS;
  endfunction

  function automatic void mdl_clear();
    mdl.delete();
    order.delete();
  endfunction

  // Train: existing entry retrains and becomes most recent; taken new entry evicts the
  // least recently trained entry of its set when the set already holds two.
  function automatic void mdl_update(input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
    logic [29:0] k = pc[31:2];
    int cnt = 0, first = -1;
    if (mdl.exists(k)) begin
      mdl[k].tgt = tgt;
      mdl[k].ctr = tk ? ((mdl[k].ctr < 3) ? mdl[k].ctr + 1 : 3) : ((mdl[k].ctr > 0) ? mdl[k].ctr - 1 : 0);
      for (int i = 0; i < order.size(); i++)
        if (order[i] == k) begin order.delete(i); break; end
      order.push_back(k);
    end else if (tk) begin
      for (int i = 0; i < order.size(); i++)
        if (set_of(order[i]) == set_of(k)) begin
          cnt++;
          if (first < 0) first = i;
        end
      if (cnt >= 2) begin
        mdl.delete(order[first]);
        order.delete(first);
      end
      mdl[k] = '{tgt: tgt, ctr: 2};
      order.push_back(k);
    end
  endfunction

  function automatic void mdl_lookup(input logic [31:0] pf, input logic ue, input logic [31:0] pe,
                                     input logic [31:0] te, input logic tk,
                                     output logic h, output logic t, output logic [31:0] tg);
    h = 1'b0; t = 1'b0; tg = '0;
    if (sweep_left > 0) return;
    if (ue && pe == pf) begin
      h = 1'b1; t = tk; tg = te;
    end else if (mdl.exists(pf[31:2])) begin
      h = 1'b1; t = (mdl[pf[31:2]].ctr >= 2); tg = mdl[pf[31:2]].tgt;
    end
  endfunction

  // One cycle: drive after negedge, compare combinational outputs, then advance the model.
  task automatic step(input string tag, input logic [31:0] pf, input logic ue,
                      input logic [31:0] pe, input logic [31:0] te, input logic tk);
    logic eh, et;
    logic [31:0] etg;
    @(negedge clk);
    PC_F = pf; upd_en_EX = ue; PC_EX = pe; target_EX = te; taken_EX = tk;
`ifdef BTB_INVALIDATE_EN
    flush_req = flush_drv;
`endif
    #1;
    mdl_lookup(pf, ue, pe, te, tk, eh, et, etg);
    obs_hit = hit_F; obs_tk = taken_F; obs_tg = target_F;
    check({tag, "_hit"}, 32'(hit_F), 32'(eh));
    check({tag, "_taken"}, 32'(taken_F), 32'(et));
    check({tag, "_target"}, target_F, etg);
    check({tag, "_busy"}, 32'(busy), 32'(sweep_left > 0));
    @(posedge clk);
    if (sweep_left > 0) sweep_left--;
    else begin
      if (ue) mdl_update(pe, te, tk);
`ifdef BTB_INVALIDATE_EN
      if (flush_drv) begin mdl_clear(); sweep_left = SETS; end
`endif
    end
  endtask

  task automatic look(input string tag, input logic [31:0] pf);
    step(tag, pf, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b0; upd_en_EX = 1'b0; flush_drv = 1'b0;
`ifdef BTB_INVALIDATE_EN
    flush_req = 1'b0;
`endif
    #1;
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_hit"}, 32'(hit_F), 32'd0);
    check({tag, "_taken"}, 32'(taken_F), 32'd0);
    check({tag, "_target"}, target_F, 32'd0);
    mdl_clear();
    sweep_left = 0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] pc = 32'h1000 + 32'($urandom_range(0, 3) * SETS * 4) + 32'($urandom_range(0, 3) * 4);
    if ($urandom_range(0, 7) == 0) pc = pc + 32'($urandom_range(1, 3));
    return pc;
  endfunction

  initial begin
    PC_F = 32'h100;
    do_reset("reset");
    look("rst_lookup", 32'h100);
    check("rst_lookup_const", 32'(obs_hit), 32'd0);

    step("upd_100", 32'h300, 1'b1, 32'h100, 32'h200, 1'b1);
    look("hit_100", 32'h100);
    check("hit_100_const", {obs_tg[31:2], obs_hit, obs_tk}, 32'h203);

    step("bypass_104", 32'h104, 1'b1, 32'h104, 32'h300, 1'b1);
    check("bypass_104_const", obs_tg, 32'h300);
    look("hit_104", 32'h104);

    step("nt1", 32'h0, 1'b1, 32'h100, 32'h200, 1'b0);
    look("ctr01", 32'h100);
    step("nt2", 32'h0, 1'b1, 32'h100, 32'h200, 1'b0);
    look("ctr00", 32'h100);
    check("ctr00_const", {31'(0), obs_hit}, 32'd1);
    step("nt3", 32'h0, 1'b1, 32'h100, 32'h200, 1'b0);
    look("ctr00_sat", 32'h100);
    step("t1", 32'h0, 1'b1, 32'h100, 32'h200, 1'b1);
    look("ctr01_up", 32'h100);
    step("t2", 32'h0, 1'b1, 32'h100, 32'h200, 1'b1);
    look("ctr10_up", 32'h100);

    step("alloc_200", 32'h0, 1'b1, 32'h200, 32'h2222, 1'b1);
    step("alloc_300", 32'h0, 1'b1, 32'h300, 32'h3333, 1'b1);
    look("evict_100", 32'h100);
    check("evict_100_const", 32'(obs_hit), 32'd0);
    look("keep_200", 32'h200);
    look("keep_300", 32'h300);
    step("nt_miss", 32'h0, 1'b1, 32'h500, 32'h5555, 1'b0);
    look("nt_noalloc", 32'h500);

`ifdef BTB_INVALIDATE_EN
    flush_drv = 1'b1;
    look("flush_go", 32'h200);
    flush_drv = 1'b0;
    for (int i = 0; i < SETS; i++) begin
      flush_drv = (i == 10);
      step("sweep", 32'h300, 1'b1, 32'h100, 32'h1234, 1'b1);
    end
    flush_drv = 1'b0;
    look("post_sweep_200", 32'h200);
    look("post_sweep_100", 32'h100);
    step("refill", 32'h0, 1'b1, 32'h100, 32'h4444, 1'b1);
    flush_drv = 1'b1;
    look("flush_go2", 32'h100);
    flush_drv = 1'b0;
    for (int i = 0; i < 10; i++) look("sweep2", 32'h100);
    do_reset("mid_sweep_rst");
    look("after_rst", 32'h100);
`endif

    for (int i = 0; i < 1500; i++) begin
      logic [31:0] pe, pf;
      logic ue;
      pe = rand_pc();
      ue = ($urandom_range(0, 9) < 7);
      pf = ($urandom_range(0, 3) == 0) ? pe : rand_pc();
`ifdef BTB_INVALIDATE_EN
      flush_drv = ($urandom_range(0, 299) == 0);
`endif
      step("rand", pf, ue, pe, $urandom(), ($urandom_range(0, 9) < 6));
    end
    flush_drv = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
